// File: rtl/arm_instr_encoder.sv
// Assembles 32-bit machine words from instruction descriptors and writes them to
// consecutive instruction-memory addresses. One word per 2 cycles; rejects undecodable descriptors.
module arm_instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        in_kind,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_cmd,
  input  logic              in_s,
  input  logic              in_imm,
  input  logic              in_load,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [23:0]       in_operand,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   prog_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [1:0] KIND_DP  = 2'b00;
  localparam logic [1:0] KIND_MEM = 2'b01;
  localparam logic [1:0] KIND_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] ERR_KIND = 2'b01;
  localparam logic [1:0] ERR_CMD  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [1:0]        err_q, err_d;

  logic [31:0]       enc_word;
  logic              cmd_ok;
  logic              s_eff;
  logic [3:0]        rd_eff;
  logic [11:0]       dp_src2;

  always_comb begin
    cmd_ok = 1'b0;
    case (in_cmd)
      CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR, CMD_CMP: cmd_ok = 1'b1;
      default:                                     cmd_ok = 1'b0;
    endcase
  end

  // CMP only exists to set flags, so S is forced and Rd is zeroed regardless of inputs.
  always_comb begin
    s_eff    = in_s;
    rd_eff   = in_rd;
    dp_src2  = in_imm ? in_operand[11:0] : {8'h00, in_operand[3:0]};
    enc_word = 32'h0;
    if (in_cmd == CMD_CMP) begin
      s_eff  = 1'b1;
      rd_eff = 4'b0000;
    end
    case (in_kind)
      KIND_DP:  enc_word = {in_cond, 2'b00, in_imm, in_cmd, s_eff, in_rn, rd_eff, dp_src2};
      KIND_MEM: enc_word = {in_cond, 2'b01, 5'b01100, in_load, in_rn, in_rd, in_operand[11:0]};
      KIND_BR:  enc_word = {in_cond, 4'b1010, in_operand};
      default:  enc_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    last_d  = last_q;
    maddr_d = maddr_q;
    err_d   = err_q;
    if (start) begin
      state_d = S_LOAD;
      addr_d  = '0;
      count_d = '0;
      err_d   = 2'b00;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            if (in_kind == 2'b11) begin
              state_d = S_ERROR;
              err_d   = ERR_KIND;
            end else if (in_kind == KIND_DP && !cmd_ok) begin
              state_d = S_ERROR;
              err_d   = ERR_CMD;
            end else if (count_q == COUNT_FULL) begin
              state_d = S_ERROR;
              err_d   = ERR_OVF;
            end else begin
              state_d = S_WRITE;
              word_d  = enc_word;
              last_d  = in_last;
              maddr_d = addr_q;
            end
          end
        end
        S_WRITE: begin
          addr_d  = addr_q + ADDR_ONE;
          count_d = count_q + COUNT_ONE;
          state_d = last_q ? S_DONE : S_LOAD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= 32'h0;
      last_q  <= 1'b0;
      maddr_q <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      last_q  <= last_d;
      maddr_q <= maddr_d;
      err_q   <= err_d;
    end
  end

  // A start arriving during WRITE kills the strobe that same cycle so the aborted word never lands.
  assign mem_we    = (state_q == S_WRITE) && !start;
  assign in_ready  = (state_q == S_LOAD) && !start;
  assign mem_addr  = maddr_q;
  assign mem_wdata = word_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign err_code  = err_q;
  assign prog_len  = count_q;

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Directed bench for arm_instr_encoder with a 2-bit address so overflow is reachable quickly.
module tb_arm_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [1:0]    in_kind = 2'b00;
  logic [3:0]    in_cond = 4'h0;
  logic [3:0]    in_cmd = 4'h0;
  logic          in_s = 1'b0;
  logic          in_imm = 1'b0;
  logic          in_load = 1'b0;
  logic [3:0]    in_rn = 4'h0;
  logic [3:0]    in_rd = 4'h0;
  logic [23:0]   in_operand = 24'h0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW:0]   prog_len;

  int checks = 0;
  int errors = 0;

  arm_instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_kind(in_kind), .in_cond(in_cond), .in_cmd(in_cmd), .in_s(in_s),
    .in_imm(in_imm), .in_load(in_load), .in_rn(in_rn), .in_rd(in_rd),
    .in_operand(in_operand),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
  endtask

  // Presents a descriptor and returns 1 time unit after the accepting edge.
  task automatic put(input logic [1:0] k, input logic [3:0] cond, input logic [3:0] cmd,
                     input logic s, input logic imm, input logic ld, input logic [3:0] rn,
                     input logic [3:0] rd, input logic [23:0] op, input logic last);
    int n;
    in_kind = k; in_cond = cond; in_cmd = cmd; in_s = s; in_imm = imm; in_load = ld;
    in_rn = rn; in_rd = rd; in_operand = op; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL put_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, mem_we, busy, done, error, err_code, prog_len, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b we=%0b busy=%0b done=%0b err=%0b code=%0d len=%0d addr=%0d wdata=%h required all 0",
               in_ready, mem_we, busy, done, error, err_code, prog_len, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, busy} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_ready: rdy=%0b busy=%0b required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_dp_add();
    pulse_start();
    checks++;
    if ({in_ready, busy, prog_len} !== {1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL start_load: rdy=%0b busy=%0b len=%0d required 1 1 0", in_ready, busy, prog_len);
    end
    put(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 24'h000005, 1'b0);
    checks++;
    if ({mem_we, in_ready, mem_addr, mem_wdata} !== {1'b1, 1'b0, 2'd0, 32'hE2821005}) begin
      errors++;
      $display("FAIL add_write: we=%0b rdy=%0b addr=%0d wdata=%h required 1 0 0 e2821005",
               mem_we, in_ready, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({mem_we, in_ready, done, prog_len} !== {1'b0, 1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL add_after: we=%0b rdy=%0b done=%0b len=%0d required 0 1 0 1",
               mem_we, in_ready, done, prog_len);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    put(2'b00, 4'hE, 4'b0010, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 24'h000004, 1'b0);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd0, 32'hE0533004}) begin
      errors++;
      $display("FAIL subs_write: we=%0b addr=%0d wdata=%h required 1 0 e0533004", mem_we, mem_addr, mem_wdata);
    end
    put(2'b00, 4'hE, 4'b1010, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 24'h000000, 1'b1);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd1, 32'hE3500000}) begin
      errors++;
      $display("FAIL cmp_write: we=%0b addr=%0d wdata=%h required 1 1 e3500000", mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, in_ready, mem_we, prog_len} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd2}) begin
      errors++;
      $display("FAIL b2b_done: done=%0b busy=%0b rdy=%0b we=%0b len=%0d required 1 0 0 0 2",
               done, busy, in_ready, mem_we, prog_len);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done, mem_wdata} !== {1'b1, 32'hE3500000}) begin
      errors++;
      $display("FAIL done_hold: done=%0b wdata=%h required 1 e3500000", done, mem_wdata);
    end
  endtask

  task automatic test_mem_branch();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hE5902008;
    exp_w[1] = 32'hE5802008;
    exp_w[2] = 32'hEA000002;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      // Unused fields carry junk (illegal cmd for MEM, registers for B) that must be ignored.
      case (i)
        0: put(2'b01, 4'hE, 4'b0001, 1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 24'hFFF008, 1'b0);
        1: put(2'b01, 4'hE, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 24'h000008, 1'b0);
        default: put(2'b10, 4'hE, 4'b0111, 1'b1, 1'b1, 1'b1, 4'd9, 4'd5, 24'h000002, 1'b1);
      endcase
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, i[AW-1:0], exp_w[i]}) begin
        errors++;
        $display("FAIL memb_write%0d: we=%0b addr=%0d wdata=%h required 1 %0d %h",
                 i, mem_we, mem_addr, mem_wdata, i, exp_w[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({done, error, prog_len} !== {1'b1, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL memb_done: done=%0b err=%0b len=%0d required 1 0 3", done, error, prog_len);
    end
  endtask

  task automatic test_illegal();
    pulse_start();
    put(2'b00, 4'hE, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 24'h000001, 1'b0);
    checks++;
    if ({mem_we, error, err_code, in_ready, busy} !== {1'b0, 1'b1, 2'b10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bad_cmd: we=%0b err=%0b code=%0d rdy=%0b busy=%0b required 0 1 2 0 0",
               mem_we, error, err_code, in_ready, busy);
    end
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({error, in_ready, mem_we, prog_len} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL err_hold: err=%0b rdy=%0b we=%0b len=%0d required 1 0 0 0", error, in_ready, mem_we, prog_len);
    end
    in_valid = 1'b0;
    pulse_start();
    checks++;
    if ({error, err_code, in_ready, prog_len} !== {1'b0, 2'b00, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL err_clear: err=%0b code=%0d rdy=%0b len=%0d required 0 0 1 0", error, err_code, in_ready, prog_len);
    end
    put(2'b11, 4'hE, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 24'h0, 1'b0);
    checks++;
    if ({mem_we, error, err_code} !== {1'b0, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL bad_kind: we=%0b err=%0b code=%0d required 0 1 1", mem_we, error, err_code);
    end
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      put(2'b00, 4'h0, 4'b1100, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 24'h0000FF, 1'b0);
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, i[AW-1:0], 32'h038120FF}) begin
        errors++;
        $display("FAIL ovf_write%0d: we=%0b addr=%0d wdata=%h required 1 %0d 038120ff",
                 i, mem_we, mem_addr, mem_wdata, i);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({in_ready, prog_len} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL ovf_full: rdy=%0b len=%0d required 1 4", in_ready, prog_len);
    end
    put(2'b10, 4'hE, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 24'h000001, 1'b1);
    checks++;
    if ({mem_we, error, err_code, prog_len} !== {1'b0, 1'b1, 2'b11, 3'd4}) begin
      errors++;
      $display("FAIL ovf_err: we=%0b err=%0b code=%0d len=%0d required 0 1 3 4",
               mem_we, error, err_code, prog_len);
    end
  endtask

  task automatic test_abort();
    pulse_start();
    put(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 24'h000005, 1'b0);
    start = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_we: we=%0b required 0", mem_we);
    end
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    checks++;
    if ({in_ready, prog_len} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL abort_state: rdy=%0b len=%0d required 1 0", in_ready, prog_len);
    end
    put(2'b10, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 24'h123456, 1'b1);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd0, 32'h0A123456}) begin
      errors++;
      $display("FAIL abort_restart: we=%0b addr=%0d wdata=%h required 1 0 0a123456", mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset_mid_write();
    pulse_start();
    put(2'b00, 4'hE, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 24'h000003, 1'b0);
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_we: we=%0b required 1", mem_we);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, busy, done, error, err_code, prog_len, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid_write: rdy=%0b we=%0b busy=%0b done=%0b err=%0b code=%0d len=%0d addr=%0d wdata=%h required all 0",
               in_ready, mem_we, busy, done, error, err_code, prog_len, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, mem_we, busy, done, error, prog_len} !== '0) begin
      errors++;
      $display("FAIL rst_release_idle: rdy=%0b we=%0b busy=%0b done=%0b err=%0b len=%0d required all 0",
               in_ready, mem_we, busy, done, error, prog_len);
    end
  endtask

  initial begin
    test_reset();
    test_dp_add();
    test_back_to_back();
    test_mem_branch();
    test_illegal();
    test_overflow();
    test_abort();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
